sb_config_loader: RTL and testbench

//  Loads the 384-bit connection configuration of one 8x8 switch box (64 switch units x 6 pass-gate enables).

---
 rtl/sb_config_loader.sv | 117 +++++++++++
 tb/tb_sb_config_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_config_loader.sv
// Switch-box configuration loader: streams NWORDS bytes plus an XOR checksum into a shadow
// register and commits the whole pattern to the live switch box in one cycle.
module sb_config_loader #(
  parameter int unsigned CFG_BITS = 384,
  parameter int unsigned WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CFG_BITS-1:0] sram_con_bit,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned NWORDS = CFG_BITS / WORD_W;
  localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LastWord = CNT_W'(NWORDS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StCheck  = 3'd2;
  localparam logic [2:0] StCommit = 3'd3;
  localparam logic [2:0] StError  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  assign in_ready     = (state_q == StLoad) || (state_q == StCheck);
  assign busy         = (state_q != StIdle);
  assign sram_con_bit = cfg_q;
  assign done         = done_q;
  assign err          = err_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StLoad;
          count_d = '0;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        // abort takes priority over a transfer in the same cycle
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          shadow_d[WORD_W*count_q +: WORD_W] = in_data;
          acc_d   = acc_q ^ in_data;
          count_d = count_q + CNT_W'(1);
          if (count_q == LastWord) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          state_d = (in_data == acc_q) ? StCommit : StError;
        end
      end
      StCommit: begin
        cfg_d   = shadow_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StError: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// Randomised self-checking bench for sb_config_loader against a transaction-level model.
module tb_sb_config_loader;

  localparam int CFG_BITS = 384;
  localparam int WORD_W   = 8;
  localparam int NWORDS   = CFG_BITS / WORD_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic [WORD_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [CFG_BITS-1:0] sram_con_bit;
  logic                busy;
  logic                done;
  logic                err;

  always #5 clk = ~clk;

  sb_config_loader #(
    .CFG_BITS(CFG_BITS),
    .WORD_W  (WORD_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sram_con_bit(sram_con_bit),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  // Model: a load is a list of received words; the checksum is judged on the whole list.
  bit                  m_active  = 1'b0;
  bit                  m_commit  = 1'b0;
  bit                  m_error   = 1'b0;
  bit                  m_done    = 1'b0;
  bit                  m_err     = 1'b0;
  logic [CFG_BITS-1:0] m_cfg     = '0;
  logic [WORD_W-1:0]   m_words[$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0;
      m_commit = 1'b0;
      m_error  = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_cfg    = '0;
      m_words.delete();
    end else begin
      m_done = 1'b0;
      if (m_commit) begin
        for (int k = 0; k < NWORDS; k++) m_cfg[k*WORD_W +: WORD_W] = m_words[k];
        m_done   = 1'b1;
        m_commit = 1'b0;
      end else if (m_error) begin
        m_err   = 1'b1;
        m_error = 1'b0;
      end else if (m_active) begin
        if (abort) begin
          m_active = 1'b0;
        end else if (in_valid) begin
          if (m_words.size() < NWORDS) begin
            m_words.push_back(in_data);
          end else begin
            logic [WORD_W-1:0] x;
            x = '0;
            foreach (m_words[k]) x = x ^ m_words[k];
            if (x == in_data) m_commit = 1'b1;
            else              m_error  = 1'b1;
            m_active = 1'b0;
          end
        end
      end else if (start && !abort) begin
        m_active = 1'b1;
        m_err    = 1'b0;
        m_words.delete();
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    vectors++;
    if (done === 1'b1) done_cnt++;
    if (busy !== (m_active | m_commit | m_error) || in_ready !== m_active ||
        done !== m_done || err !== m_err || sram_con_bit !== m_cfg) begin
      miscompares++;
      $display("FAIL cycle t=%0t (dut/model) busy %b/%b ready %b/%b done %b/%b err %b/%b cfg %h/%h",
               $time, busy, (m_active | m_commit | m_error), in_ready, m_active, done, m_done,
               err, m_err, sram_con_bit, m_cfg);
    end
  end

  task automatic pin(input string name, input logic [CFG_BITS-1:0] act,
                     input logic [CFG_BITS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WORD_W-1:0]   wbuf[NWORDS];
  logic [CFG_BITS-1:0] s1_exp;

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] b, input bit gaps);
    bit sent;
    bit v;
    sent = 1'b0;
    for (int a = 0; a < 40 && !sent; a++) begin
      v        = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      in_data  = v ? b : WORD_W'($urandom);
      sent     = v && (in_ready === 1'b1);
      step();
    end
    if (!sent) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word %0h not accepted, in_ready %b required 1", b, in_ready);
    end
  endtask

  task automatic send_range(input int lo, input int hi, input bit gaps);
    for (int k = lo; k < hi; k++) send_word(wbuf[k], gaps);
  endtask

  task automatic finish_load();
    in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic load(input logic [WORD_W-1:0] cks, input bit gaps);
    do_start();
    send_range(0, NWORDS, gaps);
    send_word(cks, gaps);
    finish_load();
  endtask

  task automatic fill_seq();
    for (int k = 0; k < NWORDS; k++) wbuf[k] = WORD_W'(k + 1);
  endtask

  initial begin
    logic [WORD_W-1:0] x;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < NWORDS; k++) s1_exp[k*WORD_W +: WORD_W] = WORD_W'(k + 1);
    repeat (3) @(posedge clk);
    #1;
    pin("reset_cfg", sram_con_bit, '0);
    pin("reset_busy", busy, 0);
    rst = 1'b0;
    step();
    pin("idle_ready", in_ready, 0);

    // 1: sequential pattern, correct checksum
    fill_seq();
    done_cnt = 0;
    load(8'h30, 1'b0);
    pin("s1_byte0", sram_con_bit[7:0], 8'h01);
    pin("s1_byte47", sram_con_bit[383:376], 8'h30);
    pin("s1_full", sram_con_bit, s1_exp);
    pin("s1_model_byte1", m_cfg[15:8], 8'h02);
    pin("s1_done_pulses", done_cnt, 1);
    pin("s1_err", err, 0);

    // 2: bad checksum
    done_cnt = 0;
    load(8'h31, 1'b0);
    pin("s2_err", err, 1);
    pin("s2_done_pulses", done_cnt, 0);
    pin("s2_cfg_held", sram_con_bit, s1_exp);
    repeat (4) step();
    pin("s2_err_sticky", err, 1);
    do_start();
    pin("s2_err_cleared", err, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    pin("s2_abort_busy", busy, 0);

    // 3: random valid gaps
    done_cnt = 0;
    load(8'h30, 1'b1);
    pin("s3_full", sram_con_bit, s1_exp);
    pin("s3_done_pulses", done_cnt, 1);
    pin("s3_idle_ready", in_ready, 0);

    // 4: abort after 20 words, then all-ones load
    for (int k = 0; k < NWORDS; k++) wbuf[k] = WORD_W'($urandom);
    do_start();
    send_range(0, 20, 1'b0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5a;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    pin("s4_abort_busy", busy, 0);
    pin("s4_abort_ready", in_ready, 0);
    pin("s4_cfg_held", sram_con_bit, s1_exp);
    for (int k = 0; k < NWORDS; k++) wbuf[k] = 8'hff;
    load(8'h00, 1'b0);
    pin("s4_all_ones", sram_con_bit, {CFG_BITS{1'b1}});

    // 5: start during LOAD and start+abort in IDLE are both ignored
    fill_seq();
    done_cnt = 0;
    do_start();
    send_range(0, 10, 1'b0);
    in_valid = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    send_range(10, NWORDS, 1'b0);
    send_word(8'h30, 1'b0);
    finish_load();
    pin("s5_full", sram_con_bit, s1_exp);
    pin("s5_done_pulses", done_cnt, 1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    pin("s5_start_abort_busy", busy, 0);

    // 6: asynchronous reset mid-load
    do_start();
    send_range(0, 30, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    pin("s6_cfg", sram_con_bit, '0);
    pin("s6_busy", busy, 0);
    pin("s6_ready", in_ready, 0);
    pin("s6_done", done, 0);
    pin("s6_err", err, 0);
    step();
    rst = 1'b0;
    step();
    pin("s6_idle_after", busy, 0);

    // Random loads: random data, checksum right or wrong, gaps, occasional abort
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < NWORDS; k++) wbuf[k] = WORD_W'($urandom);
      x = '0;
      for (int k = 0; k < NWORDS; k++) x = x ^ wbuf[k];
      if ($urandom_range(0, 3) == 0) begin
        do_start();
        send_range(0, $urandom_range(0, NWORDS - 1), t[0]);
        abort = 1'b1;
        step();
        abort = 1'b0;
        finish_load();
      end else begin
        if ($urandom_range(0, 1) == 0) x = x ^ WORD_W'($urandom_range(1, 255));
        load(x, t[0]);
      end
    end

    in_valid = 1'b0;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
